// File: rtl/btb_update_queue.sv
// btb_update_queue
//   Buffers branch-resolution events from the branch unit and replays them as
//   write commands to the BTB/bimodal predictor array. The branch unit is
//   never stalled. An event that arrives while the queue is full, with no
//   dequeue in the same cycle, is dropped.
//
//   Operations issued to the BTB:
//     00 write      : vpc, target, type and the new saturated counter
//     01 strengthen : vpc and way (the BTB does its own increment)
//     10 invalidate : vpc only
//   Fields that an op does not use are stored and driven as 0.
//
//   Ports
//     cpu_clock_i, cpu_reset_i : clock, async active-high reset
//     excp_i, bm_mod_i         : event pulses (excp_i wins when both are high)
//     vpc_i .. way_i           : event payload from the branch unit
//     btb_wr_*                 : valid/ready command port to the BTB
//     drop_count_o             : saturating count of dropped events
//
//   Optional feature: define BTB_UPDQ_STATS_EN to build the drop counter.
//   When it is undefined, drop_count_o is tied to 0.
module btb_update_queue #(
    parameter int DEPTH = 4
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_i,
    input  logic        excp_i,
    input  logic        bm_mod_i,
    input  logic [31:0] vpc_i,
    input  logic [31:0] target_i,
    input  logic [1:0]  cntr_pred_i,
    input  logic        tkn_i,
    input  logic [1:0]  type_i,
    input  logic        present_i,
    input  logic        way_i,
    output logic        btb_wr_valid_o,
    input  logic        btb_wr_ready_i,
    output logic [1:0]  btb_wr_op_o,
    output logic [31:0] btb_wr_vpc_o,
    output logic [31:0] btb_wr_target_o,
    output logic [1:0]  btb_wr_type_o,
    output logic [1:0]  btb_wr_cntr_o,
    output logic        btb_wr_way_o,
    output logic [15:0] drop_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_STRONG = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] vpc;
        logic [31:0] target;
        logic [1:0]  typ;
        logic [1:0]  cntr;
        logic        way;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      new_entry;
    entry_t      head;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        ev;
    logic        deq;
    logic        enq;
    logic [1:0]  cntr_new;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ev    = excp_i | bm_mod_i;
    assign deq   = btb_wr_valid_o & btb_wr_ready_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign enq   = ev & (!full | deq);

    always_comb begin
        cntr_new = cntr_pred_i;
        if (tkn_i) begin
            if (cntr_pred_i != 2'd3) cntr_new = cntr_pred_i + 2'd1;
        end else begin
            if (cntr_pred_i != 2'd0) cntr_new = cntr_pred_i - 2'd1;
        end
    end

    always_comb begin
        new_entry = '0;
        if (excp_i) begin
            new_entry.vpc = vpc_i;
            if (present_i) begin
                new_entry.op     = OP_WRITE;
                new_entry.target = target_i;
                new_entry.typ    = type_i;
                new_entry.cntr   = cntr_new;
            end else begin
                new_entry.op = OP_INVAL;
            end
        end else if (bm_mod_i) begin
            new_entry.op  = OP_STRONG;
            new_entry.vpc = vpc_i;
            new_entry.way = way_i;
        end
    end

    // Storage needs no reset: outputs are forced to 0 while the queue is empty.
    always_ff @(posedge cpu_clock_i) begin
        if (enq) mem[wr_ptr[AW-1:0]] <= new_entry;
    end

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    assign head            = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign btb_wr_valid_o  = !empty;
    assign btb_wr_op_o     = head.op;
    assign btb_wr_vpc_o    = head.vpc;
    assign btb_wr_target_o = head.target;
    assign btb_wr_type_o   = head.typ;
    assign btb_wr_cntr_o   = head.cntr;
    assign btb_wr_way_o    = head.way;

`ifdef BTB_UPDQ_STATS_EN
    logic        drop;
    logic [15:0] drop_cnt;

    assign drop = ev & full & !deq;

    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i)                       drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end

    assign drop_count_o = drop_cnt;
`else
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed testbench for btb_update_queue (DEPTH = 4).
module tb_btb_update_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        excp, bm_mod, tkn, present, way, ready;
    logic [31:0] vpc, target;
    logic [1:0]  cntr_pred, typ;
    logic        v;
    logic [1:0]  op, otype, ocntr;
    logic [31:0] ovpc, otarget;
    logic        oway;
    logic [15:0] drops;

    int tests = 0;
    int fails = 0;
    int exp_drops = 0;

    always #5 clk = ~clk;

    btb_update_queue #(.DEPTH(4)) dut (
        .cpu_clock_i(clk), .cpu_reset_i(rst),
        .excp_i(excp), .bm_mod_i(bm_mod), .vpc_i(vpc), .target_i(target),
        .cntr_pred_i(cntr_pred), .tkn_i(tkn), .type_i(typ), .present_i(present),
        .way_i(way), .btb_wr_valid_o(v), .btb_wr_ready_i(ready),
        .btb_wr_op_o(op), .btb_wr_vpc_o(ovpc), .btb_wr_target_o(otarget),
        .btb_wr_type_o(otype), .btb_wr_cntr_o(ocntr), .btb_wr_way_o(oway),
        .drop_count_o(drops)
    );

    // One-cycle event pulse; returns #1 after the capturing edge.
    task automatic drive(input logic ex, input logic bm, input logic pr, input logic tk,
                         input logic [1:0] cp, input logic [1:0] ty,
                         input logic [31:0] pc, input logic [31:0] tg, input logic wy);
        excp = ex; bm_mod = bm; present = pr; tkn = tk; cntr_pred = cp;
        typ = ty; vpc = pc; target = tg; way = wy;
        @(posedge clk); #1;
        excp = 1'b0; bm_mod = 1'b0;
    endtask

    task automatic drain();
        ready = 1'b1;
        for (int k = 0; k < 20 && v; k++) begin @(posedge clk); #1; end
        ready = 1'b0;
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL drain_empty valid=%b want 0", v); end
    endtask

    task automatic test_reset();
        rst = 1'b1; excp = 0; bm_mod = 0; present = 0; tkn = 0; way = 0; ready = 0;
        vpc = '0; target = '0; cntr_pred = '0; typ = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", v); end
        tests++; if ({op, ovpc, otarget, otype, ocntr, oway} !== '0) begin fails++; $display("FAIL reset_data got %h want 0", {op, ovpc, otarget, otype, ocntr, oway}); end
        tests++; if (drops !== 16'd0) begin fails++; $display("FAIL reset_drops got %0d want 0", drops); end
    endtask

    task automatic test_write();
        @(negedge clk);
        drive(1, 0, 1, 1, 2'd2, 2'b00, 32'h1000, 32'h2000, 1);
        tests++; if (v !== 1'b1) begin fails++; $display("FAIL write_valid got %b want 1", v); end
        tests++; if (op !== 2'b00) begin fails++; $display("FAIL write_op got %b want 00", op); end
        tests++; if (ocntr !== 2'd3) begin fails++; $display("FAIL write_cntr got %0d want 3", ocntr); end
        tests++; if (ovpc !== 32'h1000) begin fails++; $display("FAIL write_vpc got %h want 1000", ovpc); end
        tests++; if (otarget !== 32'h2000) begin fails++; $display("FAIL write_target got %h want 2000", otarget); end
        tests++; if ({otype, oway} !== 3'b000) begin fails++; $display("FAIL write_type_way got %b want 000", {otype, oway}); end
        drain();
    endtask

    task automatic test_saturate();
        drive(1, 0, 1, 0, 2'd0, 2'b00, 32'h1004, 32'h2004, 0);
        tests++; if ({op, ocntr} !== 4'b0000) begin fails++; $display("FAIL sat_low got op=%b cntr=%0d want 00/0", op, ocntr); end
        drain();
        drive(1, 0, 1, 1, 2'd3, 2'b10, 32'h1008, 32'h2008, 0);
        tests++; if ({op, ocntr, otype} !== 6'b00_11_10) begin fails++; $display("FAIL sat_high got op=%b cntr=%0d type=%b want 00/3/10", op, ocntr, otype); end
        drain();
        drive(1, 0, 1, 0, 2'd2, 2'b00, 32'h100C, 32'h200C, 0);
        tests++; if (ocntr !== 2'd1) begin fails++; $display("FAIL dec got %0d want 1", ocntr); end
        drain();
    endtask

    task automatic test_inval_strengthen();
        drive(1, 0, 0, 1, 2'd1, 2'b10, 32'h44, 32'h55, 1);
        tests++; if (op !== 2'b10 || ovpc !== 32'h44) begin fails++; $display("FAIL inval got op=%b vpc=%h want 10/44", op, ovpc); end
        tests++; if ({otarget, otype, ocntr, oway} !== '0) begin fails++; $display("FAIL inval_zero got %h want 0", {otarget, otype, ocntr, oway}); end
        drain();
        drive(0, 1, 1, 1, 2'd2, 2'b10, 32'h80, 32'h99, 1);
        tests++; if (op !== 2'b01 || oway !== 1'b1 || ovpc !== 32'h80) begin fails++; $display("FAIL strong got op=%b way=%b vpc=%h want 01/1/80", op, oway, ovpc); end
        tests++; if ({otarget, otype, ocntr} !== '0) begin fails++; $display("FAIL strong_zero got %h want 0", {otarget, otype, ocntr}); end
        drain();
        drive(1, 1, 1, 1, 2'd1, 2'b00, 32'h90, 32'hA0, 1);
        tests++; if (op !== 2'b00 || ocntr !== 2'd2 || oway !== 1'b0) begin fails++; $display("FAIL excp_wins got op=%b cntr=%0d way=%b want 00/2/0", op, ocntr, oway); end
        drain();
    endtask

    task automatic test_full_drop();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 1, 2'd0, 2'b00, 32'h100 + 32'(i) * 4, 32'h900 + 32'(i), 0);
            tests++; if (ovpc !== 32'h100 || otarget !== 32'h900 || ocntr !== 2'd1) begin fails++; $display("FAIL hold_stable[%0d] got vpc=%h tgt=%h want 100/900", i, ovpc, otarget); end
        end
`ifdef BTB_UPDQ_STATS_EN
        exp_drops = 1;
`else
        exp_drops = 0;
`endif
        tests++; if (drops !== 16'(exp_drops)) begin fails++; $display("FAIL drop_count got %0d want %0d", drops, exp_drops); end
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (v !== 1'b1 || ovpc !== 32'h100 + 32'(i) * 4) begin fails++; $display("FAIL drain_order[%0d] got v=%b vpc=%h want %h", i, v, ovpc, 32'h100 + 32'(i) * 4); end
            @(posedge clk); #1;
        end
        ready = 1'b0;
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL drain_count valid=%b want 0 after 4", v); end
    endtask

    task automatic test_wrap();
        logic [31:0] q[$];
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 0, 2'd0, 2'b00, 32'h3000 + 32'(i), 32'h0, 0);
            q.push_back(32'h3000 + 32'(i));
        end
        ready = 1'b1;
        for (int i = 4; i < 12; i++) begin
            excp = 1'b0; bm_mod = 1'b1; vpc = 32'h3000 + 32'(i);
            tests++; if (v !== 1'b1 || ovpc !== q[0]) begin fails++; $display("FAIL wrap_full[%0d] got v=%b vpc=%h want %h", i, v, ovpc, q[0]); end
            @(posedge clk); #1;
            void'(q.pop_front()); q.push_back(32'h3000 + 32'(i));
        end
        bm_mod = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (v !== 1'b1 || ovpc !== q[0]) begin fails++; $display("FAIL wrap_tail[%0d] got v=%b vpc=%h want %h", i, v, ovpc, q[0]); end
            @(posedge clk); #1;
            void'(q.pop_front());
        end
        ready = 1'b0;
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL wrap_empty valid=%b want 0", v); end
        tests++; if (drops !== 16'(exp_drops)) begin fails++; $display("FAIL wrap_no_drop got %0d want %0d", drops, exp_drops); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 2'd0, 2'b00, 32'h500 + 32'(i), 32'h0, 0);
        tests++; if (v !== 1'b1 || ovpc !== 32'h500) begin fails++; $display("FAIL pre_reset got v=%b vpc=%h want 1/500", v, ovpc); end
        #2 rst = 1'b1;
        #1;
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL async_reset valid=%b want 0", v); end
        exp_drops = 0;
        tests++; if (drops !== 16'd0) begin fails++; $display("FAIL async_reset_drops got %0d want 0", drops); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        drive(1, 0, 1, 0, 2'd3, 2'b10, 32'h600, 32'h700, 0);
        tests++; if (v !== 1'b1 || op !== 2'b00 || ovpc !== 32'h600 || ocntr !== 2'd2) begin fails++; $display("FAIL post_reset got v=%b op=%b vpc=%h cntr=%0d want 1/00/600/2", v, op, ovpc, ocntr); end
        ready = 1'b1; @(posedge clk); #1; ready = 1'b0;
        tests++; if (v !== 1'b0) begin fails++; $display("FAIL post_reset_drain valid=%b want 0", v); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_saturate();
        test_inval_strengthen();
        test_full_drop();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers branch-resolution events from the branch unit and replays them as write commands to the BTB/bimodal predictor array. Sits directly downstream of the branch unit's registered `c1_*` outputs and upstream of the BTB write port. It converts each event into one of three BTB operations: full write with a saturated counter, in-place strengthen, or invalidate. The branch unit is never stalled; events arriving when the queue is full are dropped.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, ≥2.
- `cpu_clock_i`  in  1  clock.
- `cpu_reset_i`  in  1  reset; asynchronous, active-high.
- `excp_i`  in  1  misprediction event pulse (branch unit `rcu_excp_o`).
- `bm_mod_i`  in  1  correctly predicted taken-branch event (branch unit `c1_btb_bm_mod_o`).
- `vpc_i`  in  32  branch PC.
- `target_i`  in  32  resolved target.
- `cntr_pred_i`  in  2  bimodal counter used at prediction.
- `tkn_i`  in  1  branch taken.
- `type_i`  in  2  branch type (00 conditional, 10 jump).
- `present_i`  in  1  entry should exist in BTB.
- `way_i`  in  1  BTB way hit, for strengthen.
- `btb_wr_valid_o`  out  1  command valid.
- `btb_wr_ready_i`  in  1  BTB accepts command.
- `btb_wr_op_o`  out  2  00 write, 01 strengthen, 10 invalidate.
- `btb_wr_vpc_o`  out  32  PC.
- `btb_wr_target_o`  out  32  target (write only).
- `btb_wr_type_o`  out  2  type (write only).
- `btb_wr_cntr_o`  out  2  new counter (write only).
- `btb_wr_way_o`  out  1  way (strengthen only).
- `drop_count_o`  out  16  dropped-event count (see Configuration).

## Operation
- Event accept: `ev = excp_i | bm_mod_i`. If both are high, `excp_i` wins.
- Op encode at enqueue:
  - `excp_i & present_i` → write. Counter is `tkn_i ? sat_inc(cntr_pred_i) : sat_dec(cntr_pred_i)`. `sat_inc(3)=3`, `sat_dec(0)=0`.
  - `excp_i & !present_i` → invalidate `vpc_i`. This is harmless if the entry is absent.
  - `bm_mod_i & !excp_i` → strengthen, with `way_i` carried. The BTB performs its own saturating increment.
- Unused fields of each op are stored and driven as 0.
- Storage is a circular buffer with `log2(DEPTH)+1`-bit read/write pointers. Full when the MSBs differ and the low bits are equal; empty when the pointers are equal. Pointers wrap naturally.
- Dequeue happens when `btb_wr_valid_o & btb_wr_ready_i`.
- Enqueue happens when `ev` is high and the queue is not full, **or** when it is full and a dequeue occurs in the same cycle.
- Full with no dequeue: the event is dropped and the entry contents are unchanged.
- Empty with simultaneous `ev`: the event is enqueued. There is no same-cycle bypass.
- No coalescing. Duplicate PCs produce duplicate commands, in order.
- The queue is not flushed on pipeline flush. Predictor training is speculation-tolerant.
- Reset mid-operation discards all entries. Commands in flight are lost, and the BTB must ignore a valid that falls during reset.

## Timing
- Reset values: `btb_wr_valid_o=0`, all `btb_wr_*` data outputs 0, `drop_count_o=0`, both pointers 0.
- Latency: event at cycle N → `btb_wr_valid_o` high at N+1 (queue previously empty).
- Outputs are driven from the head entry. `btb_wr_valid_o` equals not-empty.
- Data outputs stay stable while `btb_wr_valid_o & !btb_wr_ready_i`.
- Throughput is one enqueue and one dequeue per cycle.
- Back-to-back commands are issued without bubbles while the queue is non-empty and ready stays high.

## Configuration
- `BTB_UPDQ_STATS_EN` defined:
  - `drop_count_o` increments by 1 on every dropped event, saturating at 16'hFFFF.
  - It is cleared only by reset.
- `BTB_UPDQ_STATS_EN` undefined:
  - `drop_count_o` is tied to 0.
  - No counter logic is built.

## Test plan
- Reset, then `excp_i=1, present_i=1, tkn_i=1, cntr_pred_i=2, vpc_i=0x1000, target_i=0x2000, type_i=00` → next cycle: valid=1, op=00, cntr=3, vpc=0x1000, target=0x2000.
- `excp_i=1, present_i=1, tkn_i=0, cntr_pred_i=0` → op=00, cntr=0 (saturate low). With `cntr_pred_i=3, tkn_i=1` → cntr=3.
- `excp_i=1, present_i=0, vpc_i=0x44` → op=10, vpc=0x44, target/cntr=0. Then `bm_mod_i=1, way_i=1, vpc_i=0x80` → op=01, way=1.
- Hold ready=0 and inject 5 events with DEPTH=4:
  - First 4 are queued; data stays stable.
  - The 5th is dropped, and `drop_count_o=1` with the macro, 0 without it.
  - Then ready=1 → exactly 4 commands come out in order.
- Full queue with ready=1 and `ev` in the same cycle → no drop; order preserved through pointer wrap over 3×DEPTH events.
- Assert `cpu_reset_i` asynchronously mid-stream with 3 entries queued → valid drops to 0 immediately. After release, new events are handled normally.
